// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // First set request bit searching upward from last+1, wrapping around.
    // Returns last unchanged when no request is set.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'(32'(last) + k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );

endinterface

// File: rtl/grant_dec2to4.sv
// Enabled 2:4 one-hot decoder: turns the grant index into the grant vector.
module grant_dec2to4
    import arb_pkg::*;
(
    input  logic [ID_W-1:0]    in_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] out_o
);

    // One-hot decode, all-zero when disabled
    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o[in_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin grant arbiter with IDLE/GRANT/RELEASE FSM.
// The visible outputs (gnt, gnt_id, busy, timeout) are registered one cycle
// behind the FSM, so a request seen at edge n shows as a grant after edge n+1.
// Optional hold timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input logic               clk,
    input logic               rst_n,
    rr_grant_arbiter_if.slave arb
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [ID_W-1:0] gnt_id_q;
    logic            busy_q;
    logic            any_req;
    logic            rel_now;
    logic            hold_hit;

    assign any_req = |arb.req;
    // Normal release: owner signals done or withdraws its request
    assign rel_now = arb.done[last_id_q] | ~arb.req[last_id_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       forced_q;
    logic       timeout_q;

    // Hit on the GRANT cycle whose increment would reach HOLD_MAX
    assign hold_hit = (state_q == GRANT) && ((hold_q + 8'd1) == 8'(HOLD_MAX));

    // Hold counter runs only in GRANT and sits at zero otherwise
    always_comb begin
        hold_d = 8'd0;
        if (state_q == GRANT) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Hold counter and timeout pulse, delayed to line up with visible RELEASE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            forced_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            forced_q  <= hold_hit & ~rel_now;
            timeout_q <= forced_q;
        end
    end

    assign arb.timeout = timeout_q;
`else
    logic [7:0] unused_hold_max;

    assign unused_hold_max = 8'(HOLD_MAX);
    assign hold_hit        = 1'b0;
    assign arb.timeout     = 1'b0;
`endif

    // Next-state and winner selection
    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (any_req) begin
                    state_d   = GRANT;
                    last_id_d = rr_pick(arb.req, last_id_q);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (rel_now || hold_hit) begin
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus the registered output view, one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_id_q <= ID_W'(NUM_REQ - 1);
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            busy_q    <= (state_q == GRANT);
            if (state_q == GRANT) begin
                gnt_id_q <= last_id_q;
            end
        end
    end

    assign arb.gnt_id = gnt_id_q;
    assign arb.busy   = busy_q;

    grant_dec2to4 u_dec (
        .in_i  (gnt_id_q),
        .en_i  (busy_q),
        .out_o (arb.gnt)
    );

endmodule
